// File: rtl/osd_pkg.sv
// Shared constants and the OSD level-select helper for the video mixer slice.
package osd_pkg;

  localparam int C_LVL_CHAR   = 220;
  localparam int C_LVL_FUCHI  = 0;
  localparam int C_LVL_BG     = 110;
  localparam int C_H_TOTAL    = 910;
  localparam int C_HD_POS_DEF = C_H_TOTAL - 1;

  typedef enum logic [1:0] {
    SEL_BG    = 2'd0,
    SEL_CHAR  = 2'd1,
    SEL_FUCHI = 2'd2
  } lvl_sel_e;

  // Character beats outline; a masked outline falls back to background.
  function automatic lvl_sel_e osd_select(input logic osd_on,
                                          input logic chr,
                                          input logic fuchi,
                                          input logic fuchi_mask);
    lvl_sel_e sel;
    sel = SEL_BG;
    if (osd_on) begin
      if (chr)                     sel = SEL_CHAR;
      else if (fuchi && !fuchi_mask) sel = SEL_FUCHI;
    end
    return sel;
  endfunction

endpackage

// File: rtl/boxcar_avg.sv
// Running-sum boxcar averager over 2**C_AVG_LOG2 samples with warm-up valid and sync clear.
module boxcar_avg #(
  parameter int C_DAT_W    = 10,
  parameter int C_AVG_LOG2 = 3
) (
  input  logic               clk_sys,
  input  logic               rst_b,
  input  logic               sample_en,
  input  logic               clr,
  input  logic [C_DAT_W-1:0] din,
  output logic [C_DAT_W-1:0] avg,
  output logic               vld
);

  localparam int N     = 1 << C_AVG_LOG2;
  localparam int SUM_W = C_DAT_W + C_AVG_LOG2;
  localparam int WC_W  = (C_AVG_LOG2 > 0) ? C_AVG_LOG2 : 1;

  logic [C_DAT_W-1:0] dly [N];
  logic [SUM_W-1:0]   sum;
  logic [WC_W-1:0]    warm_cnt;

  // The sum never exceeds N*max(din), so modular add/subtract stays exact.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < N; i++) dly[i] <= '0;
      sum      <= '0;
      warm_cnt <= '0;
      vld      <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) dly[i] <= '0;
      sum      <= '0;
      warm_cnt <= '0;
      vld      <= 1'b0;
    end else if (sample_en) begin
      dly[0] <= din;
      for (int i = 1; i < N; i++) dly[i] <= dly[i-1];
      sum <= sum + SUM_W'(din) - SUM_W'(dly[N-1]);
      if (!vld) begin
        warm_cnt <= warm_cnt + WC_W'(1);
        if (warm_cnt == WC_W'(N - 1)) vld <= 1'b1;
      end
    end
  end

  assign avg = C_DAT_W'(sum >> C_AVG_LOG2);

endmodule

// File: rtl/osd_video_mixer.sv
// Glue between timing generator, character generator and encoder:
// clock-enable prescaler, XHD/XVD strobes, OSD luma mixer and output averager.
module osd_video_mixer
  import osd_pkg::*;
#(
  parameter int C_CE_DIV    = 4,
  parameter int C_HD_POS    = C_HD_POS_DEF,
  parameter int C_YY_W      = 8,
  parameter int C_DAT_W     = 10,
  parameter int C_AVG_LOG2  = 3,
  parameter int C_AVG_ON_EE = 0
) (
  input  logic               CK_i,
  input  logic               XAR_i,
  output logic               CK_EE_o,
  input  logic [9:0]         HCTRs_i,
  input  logic [9:0]         VCTRs_i,
  output logic               XHD_o,
  output logic               XVD_o,
  input  logic               CHAR_i,
  input  logic               FUCHI_i,
  input  logic               OSD_ON_i,
  input  logic               FUCHI_MASK_i,
  input  logic [C_YY_W-1:0]  LVL_CHAR_i,
  input  logic [C_YY_W-1:0]  LVL_FUCHI_i,
  input  logic [C_YY_W-1:0]  LVL_BG_i,
  output logic [C_YY_W-1:0]  YYs_o,
  input  logic [C_DAT_W-1:0] VIDEOs_i,
  input  logic               AVG_CLR_i,
  output logic [C_DAT_W-1:0] VIDEOs_AVG_o,
  output logic               AVG_VLD_o
);

  localparam int CNT_W = (C_CE_DIV > 1) ? $clog2(C_CE_DIV) : 1;

  logic [CNT_W-1:0]  ce_cnt;
  logic              ce_last;
  lvl_sel_e          sel;
  logic [C_YY_W-1:0] yy_next;
  logic              avg_s;

  assign ce_last = (ce_cnt == CNT_W'(C_CE_DIV - 1));

  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      ce_cnt  <= '0;
      CK_EE_o <= 1'b0;
    end else begin
      ce_cnt  <= ce_last ? '0 : ce_cnt + CNT_W'(1);
      CK_EE_o <= ce_last;
    end
  end

  always_comb begin
    sel = osd_select(OSD_ON_i, CHAR_i, FUCHI_i, FUCHI_MASK_i);
    case (sel)
      SEL_CHAR:  yy_next = LVL_CHAR_i;
      SEL_FUCHI: yy_next = LVL_FUCHI_i;
      default:   yy_next = LVL_BG_i;
    endcase
  end

  // Strobes and mixer advance on the registered enable, so they lag it by one edge.
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      XHD_o <= 1'b1;
      XVD_o <= 1'b1;
      YYs_o <= '0;
    end else if (CK_EE_o) begin
      XHD_o <= ~(HCTRs_i == 10'(C_HD_POS));
      XVD_o <= ~(VCTRs_i == 10'd0);
      YYs_o <= yy_next;
    end
  end

  assign avg_s = (C_AVG_ON_EE != 0) ? CK_EE_o : 1'b1;

  boxcar_avg #(
    .C_DAT_W    (C_DAT_W),
    .C_AVG_LOG2 (C_AVG_LOG2)
  ) u_avg (
    .clk_sys   (CK_i),
    .rst_b     (XAR_i),
    .sample_en (avg_s),
    .clr       (AVG_CLR_i),
    .din       (VIDEOs_i),
    .avg       (VIDEOs_AVG_o),
    .vld       (AVG_VLD_o)
  );

endmodule

// File: tb/tb_osd_video_mixer.sv
// Bench for osd_video_mixer: directed scenarios plus random traffic against a behavioural model.
module tb_osd_video_mixer;
  import osd_pkg::*;

  localparam int DIV = 4;
  localparam int YW  = 8;
  localparam int DW  = 10;
  localparam int N   = 8;

  logic          CK_i = 1'b0;
  logic          XAR_i;
  logic [9:0]    hctr, vctr;
  logic          chr, fuchi, osd_on, fmask, clr;
  logic [YW-1:0] lvl_char, lvl_fuchi, lvl_bg;
  logic [DW-1:0] video;

  logic          ce_a, xhd_a, xvd_a, vld_a;
  logic [YW-1:0] yy_a;
  logic [DW-1:0] avg_a;
  logic          ce_b, xhd_b, xvd_b, vld_b;
  logic [YW-1:0] yy_b;
  logic [DW-1:0] avg_b;

  always #5 CK_i = ~CK_i;

  osd_video_mixer #(.C_CE_DIV(DIV), .C_AVG_ON_EE(0)) dut (
    .CK_i(CK_i), .XAR_i(XAR_i), .CK_EE_o(ce_a), .HCTRs_i(hctr), .VCTRs_i(vctr),
    .XHD_o(xhd_a), .XVD_o(xvd_a), .CHAR_i(chr), .FUCHI_i(fuchi), .OSD_ON_i(osd_on),
    .FUCHI_MASK_i(fmask), .LVL_CHAR_i(lvl_char), .LVL_FUCHI_i(lvl_fuchi), .LVL_BG_i(lvl_bg),
    .YYs_o(yy_a), .VIDEOs_i(video), .AVG_CLR_i(clr), .VIDEOs_AVG_o(avg_a), .AVG_VLD_o(vld_a));

  osd_video_mixer #(.C_CE_DIV(DIV), .C_AVG_ON_EE(1)) dut_ee (
    .CK_i(CK_i), .XAR_i(XAR_i), .CK_EE_o(ce_b), .HCTRs_i(hctr), .VCTRs_i(vctr),
    .XHD_o(xhd_b), .XVD_o(xvd_b), .CHAR_i(chr), .FUCHI_i(fuchi), .OSD_ON_i(osd_on),
    .FUCHI_MASK_i(fmask), .LVL_CHAR_i(lvl_char), .LVL_FUCHI_i(lvl_fuchi), .LVL_BG_i(lvl_bg),
    .YYs_o(yy_b), .VIDEOs_i(video), .AVG_CLR_i(clr), .VIDEOs_AVG_o(avg_b), .AVG_VLD_o(vld_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: edge counting, sample histories since last clear.
  int edges;
  bit m_ce, m_xhd, m_xvd;
  int m_yy;
  int hist_a[$];
  int hist_b[$];
  int nsamp_a, nsamp_b;

  function automatic int q_mean(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / N;
  endfunction

  task automatic model_reset();
    edges = 0; m_ce = 0; m_xhd = 1; m_xvd = 1; m_yy = 0;
    hist_a.delete(); hist_b.delete();
    nsamp_a = 0; nsamp_b = 0;
  endtask

  task automatic model_edge();
    bit ce_was;
    ce_was = m_ce;
    edges++;
    m_ce = (edges % DIV) == 0;
    if (ce_was) begin
      m_xhd = (int'(hctr) != C_H_TOTAL - 1);
      m_xvd = (int'(vctr) != 0);
      if (!osd_on)             m_yy = int'(lvl_bg);
      else if (chr)            m_yy = int'(lvl_char);
      else if (fuchi && !fmask) m_yy = int'(lvl_fuchi);
      else                     m_yy = int'(lvl_bg);
    end
    if (clr) begin
      hist_a.delete(); nsamp_a = 0;
      hist_b.delete(); nsamp_b = 0;
    end else begin
      hist_a.push_back(int'(video)); nsamp_a++;
      if (hist_a.size() > N) void'(hist_a.pop_front());
      if (ce_was) begin
        hist_b.push_back(int'(video)); nsamp_b++;
        if (hist_b.size() > N) void'(hist_b.pop_front());
      end
    end
  endtask

  task automatic compare_all();
    check("ce",    ce_a,  m_ce);
    check("xhd",   xhd_a, m_xhd);
    check("xvd",   xvd_a, m_xvd);
    check("yy",    yy_a,  m_yy);
    check("avg",   avg_a, q_mean(hist_a));
    check("vld",   vld_a, nsamp_a >= N);
    check("ce_b",  ce_b,  m_ce);
    check("xhd_b", xhd_b, m_xhd);
    check("xvd_b", xvd_b, m_xvd);
    check("yy_b",  yy_b,  m_yy);
    check("avg_b", avg_b, q_mean(hist_b));
    check("vld_b", vld_b, nsamp_b >= N);
  endtask

  task automatic step();
    @(posedge CK_i);
    model_edge();
    @(negedge CK_i);
    compare_all();
  endtask

  task automatic osd_case(input bit on, input bit c, input bit f, input bit m,
                          input int exp, input string tag);
    osd_on = on; chr = c; fuchi = f; fmask = m;
    repeat (8) step();
    check(tag, yy_a, exp);
  endtask

  int lo_h, lo_v, n;

  initial begin
    XAR_i = 1'b0;
    osd_on = 0; chr = 0; fuchi = 0; fmask = 0; clr = 0;
    lvl_char = 8'd220; lvl_fuchi = 8'd0; lvl_bg = 8'd110;
    hctr = 10'd0; vctr = 10'd1; video = '0;
    model_reset();
    repeat (3) @(negedge CK_i);
    compare_all();
    check("rst_xhd", xhd_a, 1);
    check("rst_xvd", xvd_a, 1);
    check("rst_yy",  yy_a,  0);
    check("rst_ce",  ce_a,  0);
    XAR_i = 1'b1;

    // Prescaler phase and averager ramp up/down with a constant 800 input.
    video = 10'd800;
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) video = 10'd0;
      step();
      check("ce_edge", ce_a, (k % 4) == 0);
      check("avg_ramp", avg_a, (k <= 8) ? 100 * k : 800 - 100 * (k - 8));
      check("avg_vld", vld_a, k >= 8);
      if (k <= 4) check("yy_pre_en", yy_a, 0);
    end

    // Drive pulse width: 909 / 0 held across exactly one enable.
    lo_h = 0; lo_v = 0;
    hctr = 10'd909; vctr = 10'd0;
    for (int k = 0; k < 16; k++) begin
      if (k == 4) begin hctr = 10'd100; vctr = 10'd5; end
      step();
      lo_h += int'(!xhd_a);
      lo_v += int'(!xvd_a);
    end
    check("xhd_width", lo_h, 4);
    check("xvd_width", lo_v, 4);

    osd_case(1, 1, 1, 0, 220, "mix_char_wins");
    osd_case(1, 0, 1, 0, 0,   "mix_fuchi");
    osd_case(1, 0, 1, 1, 110, "mix_fuchi_mask");
    osd_case(0, 1, 1, 0, 110, "mix_osd_off");

    // Clear coincident with a 1023 sample, then refill.
    video = 10'd500;
    repeat (8) step();
    clr = 1; video = 10'd1023;
    step();
    clr = 0;
    check("clr_avg", avg_a, 0);
    check("clr_vld", vld_a, 0);
    video = 10'd40;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("refill_avg", avg_a, 5 * k);
      check("refill_vld", vld_a, k == 8);
    end

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      hctr   = ($urandom_range(0, 2) == 0) ? 10'd909 : 10'($urandom_range(0, 1023));
      vctr   = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      chr    = 1'($urandom_range(0, 1));
      fuchi  = 1'($urandom_range(0, 1));
      osd_on = ($urandom_range(0, 3) != 0);
      fmask  = ($urandom_range(0, 3) == 0);
      video  = 10'($urandom_range(0, 1023));
      clr    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) begin
        lvl_char  = 8'($urandom_range(0, 255));
        lvl_fuchi = 8'($urandom_range(0, 255));
        lvl_bg    = 8'($urandom_range(0, 255));
      end
      step();
    end

    // Asynchronous reset between edges clears everything at once.
    clr = 0; hctr = 10'd909; vctr = 10'd0;
    #2 XAR_i = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge CK_i);
    compare_all();
    XAR_i = 1'b1;

    // Enable-gated averager: 8th enabled sample lands on edge 33.
    hctr = 10'd3; vctr = 10'd7; video = 10'd300;
    n = 0;
    while (!vld_b && n < 100) begin
      step();
      n++;
    end
    check("ee_vld_edge", n, 33);
    check("ee_avg_full", avg_b, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
